// File: rtl/multicycle_seq.sv
// multicycle_seq: five-phase control sequencer for a multi-cycle RV32I
// datapath that shares one ALU and one memory port.
module multicycle_seq #(
    parameter int MEM_TIMEOUT     = 255,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [3:0] dec_aluop,
    input  logic [1:0] dec_alusrc,
    input  logic       dec_memread,
    input  logic       dec_memwrite,
    input  logic       dec_memtoreg,
    input  logic       dec_regwrite,
    input  logic       br_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_is_instr,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic [3:0] alu_op,
    output logic [1:0] alu_src,
    output logic [2:0] state_o,
    output logic       retired,
    output logic       trap
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_ALU,
        C_LOAD,
        C_STORE,
        C_BRANCH,
        C_JAL,
        C_JALR,
        C_ILL
    } cls_t;

    // Last waiting cycle allowed before the request is declared dead
    localparam logic [15:0] WAIT_LIM = 16'(MEM_TIMEOUT - 1);

    state_t      state;
    cls_t        cls;
    cls_t        l_cls;
    logic [15:0] wait_cnt;
    logic [3:0]  l_aluop;
    logic [1:0]  l_alusrc;
    logic        l_memread;
    logic        l_memwrite;
    logic        l_memtoreg;
    logic        l_regwrite;
    logic        timed_out;

    always_comb begin
        case (opcode)
            7'b0110011,
            7'b0010011: cls = C_ALU;
            7'b0000011: cls = C_LOAD;
            7'b0100011: cls = C_STORE;
            7'b1100011: cls = C_BRANCH;
            7'b1101111: cls = C_JAL;
            7'b1100111: cls = C_JALR;
            default:    cls = C_ILL;
        endcase
    end

    assign timed_out = !mem_ready && (wait_cnt == WAIT_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            l_cls      <= C_ALU;
            l_aluop    <= '0;
            l_alusrc   <= '0;
            l_memread  <= 1'b0;
            l_memwrite <= 1'b0;
            l_memtoreg <= 1'b0;
            l_regwrite <= 1'b0;
        end else begin
            wait_cnt <= '0;
            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready)
                        state <= S_DECODE;
                    else if (timed_out)
                        state <= S_TRAP;
                    else
                        wait_cnt <= wait_cnt + 16'd1;
                end
                S_DECODE: begin
                    l_cls      <= cls;
                    l_aluop    <= dec_aluop;
                    l_alusrc   <= dec_alusrc;
                    l_memread  <= dec_memread;
                    l_memwrite <= dec_memwrite;
                    l_memtoreg <= dec_memtoreg;
                    l_regwrite <= dec_regwrite;
                    if (cls != C_ILL)
                        state <= S_EXEC;
                    else if (TRAP_ON_ILLEGAL)
                        state <= S_TRAP;
                    else
                        state <= S_FETCH;
                end
                S_EXEC: begin
                    case (l_cls)
                        C_BRANCH:        state <= S_FETCH;
                        C_LOAD, C_STORE: state <= S_MEM;
                        default:         state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready)
                        state <= l_memread ? S_WB : S_FETCH;
                    else if (timed_out)
                        state <= S_TRAP;
                    else
                        wait_cnt <= wait_cnt + 16'd1;
                end
                S_WB:    state <= S_FETCH;
                S_TRAP:  state <= S_TRAP;
                default: state <= S_TRAP;
            endcase
        end
    end

    // Outputs decode from state so an async reset kills mem_req at once
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_is_instr = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 2'b00;
        rf_we        = 1'b0;
        wb_sel       = 2'b00;
        alu_op       = 4'b0000;
        alu_src      = 2'b00;
        retired      = 1'b0;
        trap         = 1'b0;
        state_o      = state;
        case (state)
            S_FETCH: begin
                mem_req      = 1'b1;
                mem_is_instr = 1'b1;
                ir_we        = mem_ready;
            end
            S_DECODE: begin
                if (cls == C_ILL && !TRAP_ON_ILLEGAL) begin
                    pc_we   = 1'b1;
                    retired = 1'b1;
                end
            end
            S_EXEC: begin
                alu_op  = l_aluop;
                alu_src = l_alusrc;
                case (l_cls)
                    C_BRANCH: begin
                        alu_op  = 4'b0001;
                        pc_we   = 1'b1;
                        pc_sel  = br_taken ? 2'b01 : 2'b00;
                        retired = 1'b1;
                    end
                    C_LOAD, C_STORE: begin
                        alu_op  = 4'b0000;
                        alu_src = 2'b01;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = l_memwrite;
                alu_src = 2'b01;
                if (mem_ready && !l_memread) begin
                    pc_we   = 1'b1;
                    retired = 1'b1;
                end
            end
            S_WB: begin
                rf_we   = l_regwrite;
                pc_we   = 1'b1;
                retired = 1'b1;
                case (l_cls)
                    C_JAL: begin
                        wb_sel = 2'b10;
                        pc_sel = 2'b01;
                    end
                    C_JALR: begin
                        wb_sel = 2'b10;
                        pc_sel = 2'b10;
                    end
                    default: wb_sel = l_memtoreg ? 2'b01 : 2'b00;
                endcase
            end
            S_TRAP:  trap = 1'b1;
            default: ;
        endcase
    end

endmodule
